mux_and_pipe: RTL and testbench

Parametrised, registered successor to the two-input mux-and merge cell. Selects one of `NumInputs` data channels of `Width` bits and bitwise-ANDs it with a gating mask. The result lands in a single output register with a valid/ready handshake. Used in the merge-cell library wherever a wide, gated selection must be re-timed before driving a 74-series bus. An optional round-robin mode picks the channel automatically.

---
 rtl/mux_and_pkg.sv | 12 +
 rtl/mux_and_rr_arb.sv | 40 ++++
 rtl/mux_and_pipe.sv | 81 ++++++++
 tb/tb_mux_and_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_and_pkg.sv
// Shared types and constants for the gated, registered mux-and merge cell.
// Build option MUX_AND_RR_EN (see mux_and_pipe) does not affect this package.
package mux_and_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Every bit of y_o clears to this value on reset.
  localparam logic YResetBit = 1'b0;

  typedef logic [DefaultWidth-1:0] data_t;

endpackage

// File: rtl/mux_and_rr_arb.sv
// Round-robin arbiter for mux_and_pipe: pointer register plus wrap-around
// priority search starting at the pointer. Only used with MUX_AND_RR_EN.
module mux_and_rr_arb #(
  parameter int NumInputs = 4,
  localparam int SelWidth = $clog2(NumInputs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumInputs-1:0] valid_i,
  input  logic                 advance_i,
  output logic [SelWidth-1:0]  grant_o,
  output logic                 grant_valid_o
);

  logic [SelWidth-1:0] ptr_q;
  logic [SelWidth-1:0] idx;

  // Search downwards so the valid channel closest to ptr_q wins last.
  always_comb begin
    grant_o       = '0;
    grant_valid_o = 1'b0;
    idx           = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      idx = SelWidth'((int'(ptr_q) + k) % NumInputs);
      if (valid_i[idx]) begin
        grant_o       = idx;
        grant_valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i && grant_valid_o) begin
      ptr_q <= (int'(grant_o) == NumInputs - 1) ? '0 : grant_o + 1'b1;
    end
  end

endmodule

// File: rtl/mux_and_pipe.sv
// Registered N-way select-and-mask cell with a valid/ready output stage.
// Define MUX_AND_RR_EN to add rr_mode_i and the round-robin arbiter.
module mux_and_pipe
  import mux_and_pkg::*;
#(
  parameter int NumInputs = 4,
  parameter int Width = 8,
  localparam int SelWidth = $clog2(NumInputs)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumInputs-1:0][Width-1:0]  i_i,
  input  logic [NumInputs-1:0]             valid_i,
  output logic [NumInputs-1:0]             ready_o,
  input  logic [SelWidth-1:0]              s_i,
  input  logic [Width-1:0]                 b_i,
`ifdef MUX_AND_RR_EN
  input  logic                             rr_mode_i,
`endif
  output logic [Width-1:0]                 y_o,
  output logic                             valid_o,
  input  logic                             ready_i
);

  typedef logic [Width-1:0] word_t;
  localparam word_t YResetVal = {Width{YResetBit}};

  logic                load;
  logic                sel_in_range;
  logic [SelWidth-1:0] cand;
  logic                cand_ok;
  logic                accept;

  assign load         = !valid_o || ready_i;
  assign sel_in_range = (int'(s_i) < NumInputs);

`ifdef MUX_AND_RR_EN
  logic [SelWidth-1:0] rr_grant;
  logic                rr_grant_valid;

  mux_and_rr_arb #(
    .NumInputs(NumInputs)
  ) u_rr_arb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .valid_i       (valid_i),
    .advance_i     (accept && rr_mode_i),
    .grant_o       (rr_grant),
    .grant_valid_o (rr_grant_valid)
  );

  assign cand    = rr_mode_i ? rr_grant : s_i;
  assign cand_ok = rr_mode_i ? rr_grant_valid : sel_in_range;
`else
  assign cand    = s_i;
  assign cand_ok = sel_in_range;
`endif

  assign accept = cand_ok && load && valid_i[cand];

  always_comb begin
    ready_o = '0;
    if (cand_ok) begin
      ready_o[cand] = load;
    end
  end

  // Mask is applied only on capture; a held word is never re-masked.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_o     <= YResetVal;
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o <= accept;
      if (accept) begin
        y_o <= i_i[cand] & b_i;
      end
    end
  end

endmodule

// File: tb/tb_mux_and_pipe.sv
// Self-checking bench for mux_and_pipe: behavioural model plus directed literal checks.
// Exercises the round-robin mode when compiled with MUX_AND_RR_EN.
module tb_mux_and_pipe;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

`ifdef MUX_AND_RR_EN
  localparam bit RrBuild = 1'b1;
`else
  localparam bit RrBuild = 1'b0;
`endif

  // Instance with 4 channels
  logic [3:0][7:0] d4;
  logic [3:0]      v4, r4;
  logic [1:0]      s4;
  logic [7:0]      b4, y4;
  logic            vo4, ri4, rr4;
  // Instance with 3 channels (select value 3 is out of range)
  logic [2:0][7:0] d3;
  logic [2:0]      v3, r3;
  logic [1:0]      s3;
  logic [7:0]      b3, y3;
  logic            vo3, ri3, rr3;

  int n_chk = 0;
  int n_fail = 0;

  mux_and_pipe #(.NumInputs(4), .Width(8)) dut4 (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_i(d4), .valid_i(v4), .ready_o(r4),
    .s_i(s4), .b_i(b4),
`ifdef MUX_AND_RR_EN
    .rr_mode_i(rr4),
`endif
    .y_o(y4), .valid_o(vo4), .ready_i(ri4));

  mux_and_pipe #(.NumInputs(3), .Width(8)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .i_i(d3), .valid_i(v3), .ready_o(r3),
    .s_i(s3), .b_i(b3),
`ifdef MUX_AND_RR_EN
    .rr_mode_i(rr3),
`endif
    .y_o(y3), .valid_o(vo3), .ready_i(ri3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Channel the rules pick: explicit select (or -1 if out of range), or the
  // first valid channel at or after ptr with wrap-around (-1 if none).
  function automatic int pick(int n, bit rr, int s, logic [3:0] v, int ptr);
    if (!rr) return (s < n) ? s : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int c, bit ld);
    logic [3:0] r;
    r = '0;
    if (c >= 0 && ld) r[c] = 1'b1;
    return r;
  endfunction

  // Model state
  logic [7:0] my4 = '0, my3 = '0;
  bit         mv4 = 1'b0, mv3 = 1'b0;
  int         mp4 = 0, mp3 = 0;

  always @(posedge clk_i or negedge rst_ni) begin : model
    int  c;
    bit  ld;
    if (!rst_ni) begin
      my4 <= '0; mv4 <= 1'b0; mp4 <= 0;
      my3 <= '0; mv3 <= 1'b0; mp3 <= 0;
    end else begin
      ld = !mv4 || ri4;
      c  = pick(4, RrBuild && rr4, int'(s4), v4, mp4);
      if (ld && c >= 0 && v4[c]) begin
        my4 <= d4[c] & b4;
        mv4 <= 1'b1;
        if (RrBuild && rr4) mp4 <= (c + 1) % 4;
      end else if (ld) begin
        mv4 <= 1'b0;
      end
      ld = !mv3 || ri3;
      c  = pick(3, RrBuild && rr3, int'(s3), {1'b0, v3}, mp3);
      if (ld && c >= 0 && v3[c]) begin
        my3 <= d3[c] & b3;
        mv3 <= 1'b1;
        if (RrBuild && rr3) mp3 <= (c + 1) % 3;
      end else if (ld) begin
        mv3 <= 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin : compare
    int c;
    if (rst_ni) begin
      c = pick(4, RrBuild && rr4, int'(s4), v4, mp4);
      chk("model_y4", y4, my4);
      chk("model_valid4", vo4, mv4);
      chk("model_ready4", r4, exp_ready(c, !mv4 || ri4));
      c = pick(3, RrBuild && rr3, int'(s3), {1'b0, v3}, mp3);
      chk("model_y3", y3, my3);
      chk("model_valid3", vo3, mv3);
      chk("model_ready3", {1'b0, r3}, exp_ready(c, !mv3 || ri3));
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    d4 = '0; v4 = '0; s4 = '0; b4 = '0; ri4 = 1'b1; rr4 = 1'b0;
    d3 = '0; v3 = '0; s3 = '0; b3 = '0; ri3 = 1'b1; rr3 = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    @(negedge clk_i);
    chk("reset_y", y4, 8'h00);
    chk("reset_valid", vo4, 1'b0);
    chk("reset_ready", r4, 4'b0001);

    // Explicit select on dut4; in-range then out-of-range on dut3
    cyc();
    s4 = 2'd2; d4[2] = 8'hF3; b4 = 8'h3C; v4 = 4'b0100;
    s3 = 2'd0; d3[0] = 8'h5A; b3 = 8'hFF; v3 = 3'b001;
    @(negedge clk_i);
    chk("explicit_ready", r4, 4'b0100);
    cyc();
    ri4 = 1'b0; s4 = 2'd1; d4[1] = 8'hAA; b4 = 8'hFF; v4 = 4'b0010;
    s3 = 2'd3; v3 = 3'b111;
    @(negedge clk_i);
    chk("explicit_y", y4, 8'h30);
    chk("explicit_valid", vo4, 1'b1);
    chk("oor_y_held", y3, 8'h5A);
    chk("oor_ready", r3, 3'b000);
    repeat (5) begin
      cyc();
      @(negedge clk_i);
      chk("bp_y_stable", y4, 8'h30);
      chk("bp_ready", r4, 4'b0000);
      chk("oor_drained", vo3, 1'b0);
    end
    cyc();
    ri4 = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", r4, 4'b0010);
    cyc();
    v4 = '0;
    @(negedge clk_i);
    chk("no_bubble_y", y4, 8'hAA);
    chk("no_bubble_valid", vo4, 1'b1);
    cyc();
    @(negedge clk_i);
    chk("drain_valid", vo4, 1'b0);
    chk("drain_y_hold", y4, 8'hAA);

    // Asynchronous reset in the middle of a stream
    cyc();
    v4 = 4'b1111; s4 = 2'd3; d4[3] = 8'h77; b4 = 8'hFF;
    cyc();
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_y", y4, 8'h00);
    chk("async_rst_valid", vo4, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

`ifdef MUX_AND_RR_EN
    rr4 = 1'b1; b4 = 8'hFF; v4 = 4'b1111;
    d4[0] = 8'h10; d4[1] = 8'h11; d4[2] = 8'h12; d4[3] = 8'h13;
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk_i);
      chk("rr_all_valid", y4, 8'h10 + 8'(k % 4));
    end
    v4 = 4'b1001;
    cyc();
    @(negedge clk_i);
    chk("rr_1001_first", y4, 8'h13);
    cyc();
    @(negedge clk_i);
    chk("rr_1001_second", y4, 8'h10);
    rr4 = 1'b0; s4 = 2'd2; v4 = 4'b1111;
    cyc();
    @(negedge clk_i);
    chk("mode_switch_sel", y4, 8'h12);
    rr4 = 1'b1;
    cyc();
    @(negedge clk_i);
    chk("mode_switch_ptr_kept", y4, 8'h11);
`endif

    // Randomised traffic, checked every cycle by the compare process
    for (int n = 0; n < 600; n++) begin
      cyc();
      d4 = {$urandom, $urandom} ; d3 = 24'($urandom);
      v4 = 4'($urandom); v3 = 3'($urandom);
      s4 = 2'($urandom); s3 = 2'($urandom);
      b4 = 8'($urandom); b3 = 8'($urandom);
      ri4 = ($urandom_range(0, 3) != 0);
      ri3 = ($urandom_range(0, 3) != 0);
      if (RrBuild && $urandom_range(0, 7) == 0) rr4 = ~rr4;
      if (RrBuild && $urandom_range(0, 7) == 0) rr3 = ~rr3;
    end
    cyc();
    @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
